glitch_sequencer: RTL and testbench

Arm/trigger/delay sequencer that drives the pulser in the glitch controller. Sits between the UART command handler and the pulser: latches the configured delay and trigger edge on an arm command, optionally holds the target in reset, waits for an external trigger edge, then counts the delay and issues a single start strobe to the pulser. It also owns `target_reset_o`.

---
 rtl/glitch_sequencer.sv | 139 +++++++++++++
 tb/tb_glitch_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/glitch_sequencer.sv
// rtl/glitch_sequencer.sv - arm/trigger/delay sequencer driving the glitch pulser start strobe
module glitch_sequencer #(
  parameter int RESET_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arm_i,
  input  logic        abort_i,
  input  logic        reset_target_i,
  input  logic        trig_edge_i,
  input  logic [15:0] delay_i,
  input  logic        trigger_i,
  input  logic        pulser_ready_i,
  output logic        pulse_start_o,
  output logic        target_reset_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [2:0]  state_o
);

  localparam int RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_LOAD = RC_W'(RESET_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RESET_TGT = 3'd1,
    S_WAIT_TRIG = 3'd2,
    S_DELAY     = 3'd3,
    S_FIRE      = 3'd4,
    S_WAIT_DONE = 3'd5
  } state_t;

  state_t          state, next_state;
  logic            s1, s2, s3;
  logic            edge_q;
  logic [15:0]     delay_q;
  logic [15:0]     delay_cnt;
  logic [RC_W-1:0] rst_cnt;
  logic            seen_low;
  logic            trig_hit;
  logic            latch_cfg, load_delay, load_rst, done_next;

  // Synchronizer and history run in every state so a level present at arm is never seen as an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= trigger_i;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign trig_hit = edge_q ? (s2 & ~s3) : (~s2 & s3);

  always_comb begin
    next_state = state;
    latch_cfg  = 1'b0;
    load_delay = 1'b0;
    load_rst   = 1'b0;
    done_next  = 1'b0;
    case (state)
      S_IDLE: begin
        if (arm_i && pulser_ready_i) begin
          latch_cfg = 1'b1;
          if (reset_target_i) begin
            next_state = S_RESET_TGT;
            load_rst   = 1'b1;
          end else begin
            next_state = S_WAIT_TRIG;
          end
        end
      end
      S_RESET_TGT: if (rst_cnt == '0) next_state = S_WAIT_TRIG;
      S_WAIT_TRIG: begin
        if (trig_hit) begin
          if (delay_q != 16'd0) begin
            next_state = S_DELAY;
            load_delay = 1'b1;
          end else begin
            next_state = S_FIRE;
          end
        end
      end
      S_DELAY:     if (delay_cnt == 16'd0) next_state = S_FIRE;
      S_FIRE:      next_state = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (seen_low && pulser_ready_i) begin
          next_state = S_IDLE;
          done_next  = 1'b1;
        end
      end
      default:     next_state = S_IDLE;
    endcase
    if (abort_i) begin
      next_state = S_IDLE;
      latch_cfg  = 1'b0;
      load_delay = 1'b0;
      load_rst   = 1'b0;
      done_next  = 1'b0;
    end
  end

  // Strobes are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      pulse_start_o  <= 1'b0;
      target_reset_o <= 1'b0;
      done_o         <= 1'b0;
      edge_q         <= 1'b0;
      delay_q        <= 16'd0;
      delay_cnt      <= 16'd0;
      rst_cnt        <= '0;
      seen_low       <= 1'b0;
    end else begin
      state          <= next_state;
      pulse_start_o  <= (next_state == S_FIRE);
      target_reset_o <= (next_state == S_RESET_TGT);
      done_o         <= done_next;
      if (latch_cfg) begin
        delay_q <= delay_i;
        edge_q  <= trig_edge_i;
      end
      if (load_rst) rst_cnt <= RC_LOAD;
      else if (state == S_RESET_TGT && rst_cnt != '0) rst_cnt <= rst_cnt - 1'b1;
      if (load_delay) delay_cnt <= delay_q - 16'd1;
      else if (state == S_DELAY && delay_cnt != 16'd0) delay_cnt <= delay_cnt - 16'd1;
      if (state != S_WAIT_DONE) seen_low <= 1'b0;
      else if (!pulser_ready_i) seen_low <= 1'b1;
    end
  end

  assign state_o = state;
  assign busy_o  = (state != S_IDLE);

endmodule

// File: tb/tb_glitch_sequencer.sv
// tb/tb_glitch_sequencer.sv - scoreboard bench for glitch_sequencer with randomized sequences
module tb_glitch_sequencer;
  localparam int RC = 8;
  localparam int K_TRST = 0, K_FIRE = 1, K_DONE = 2;

  logic        clk = 1'b0;
  logic        rst, arm_i, abort_i, reset_target_i, trig_edge_i, trigger_i, pulser_ready_i;
  logic [15:0] delay_i;
  logic        pulse_start_o, target_reset_o, busy_o, done_o;
  logic [2:0]  state_o;

  glitch_sequencer #(.RESET_CYCLES(RC)) dut (
    .clk(clk), .rst(rst), .arm_i(arm_i), .abort_i(abort_i),
    .reset_target_i(reset_target_i), .trig_edge_i(trig_edge_i), .delay_i(delay_i),
    .trigger_i(trigger_i), .pulser_ready_i(pulser_ready_i),
    .pulse_start_o(pulse_start_o), .target_reset_o(target_reset_o),
    .busy_o(busy_o), .done_o(done_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int cyc;
    int len;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_ev(input int kind, input int at, input int len);
    exp_t e;
    e.kind = kind;
    e.cyc  = at;
    e.len  = len;
    sb.push_back(e);
  endtask

  task automatic pop_check(input int kind, input int at, input int len);
    exp_t e;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_event: got kind %0d at cycle %0d expected none", kind, at);
    end else begin
      e = sb.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_cycle", at, e.cyc);
      if (kind == K_TRST) chk("trst_len", len, e.len);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT shows a strobe or ends a target reset pulse.
  logic tr_prev = 1'b0;
  int   tr_rise = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (pulse_start_o) pop_check(K_FIRE, cyc, 0);
      if (done_o) pop_check(K_DONE, cyc, 0);
      if (target_reset_o && !tr_prev) tr_rise = cyc;
      if (!target_reset_o && tr_prev) pop_check(K_TRST, tr_rise, cyc - tr_rise);
      tr_prev = target_reset_o;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic settle_trigger(input bit lvl);
    trigger_i = lvl;
    step(4);
  endtask

  task automatic do_arm(input bit rt, input bit rise, input int d, input int trst_len);
    int c;
    c = cyc;
    arm_i = 1'b1;
    reset_target_i = rt;
    trig_edge_i = rise;
    delay_i = 16'(d);
    if (rt) expect_ev(K_TRST, c + 1, trst_len);
    step(1);
    arm_i = 1'b0;
    delay_i = 16'($urandom);
    reset_target_i = 1'(~rt);
    trig_edge_i = 1'(~rise);
    chk("busy_after_arm", busy_o, 1);
  endtask

  // Expected fire edge: s1 captures at E0, pulse follows edge E0+2+D.
  task automatic fire(input bit rise, input int d);
    int e0;
    trigger_i = rise;
    e0 = cyc + 1;
    expect_ev(K_FIRE, e0 + 2 + d, 0);
    step(d + 5);
  endtask

  task automatic finish_pulse();
    pulser_ready_i = 1'b0;
    step(3);
    pulser_ready_i = 1'b1;
    expect_ev(K_DONE, cyc + 1, 0);
    step(3);
    chk("state_after_done", state_o, 0);
    chk("busy_after_done", busy_o, 0);
  endtask

  task automatic run_seq(input bit rt, input bit rise, input int d);
    settle_trigger(~rise);
    do_arm(rt, rise, d, RC);
    step(rt ? RC + 3 : 2);
    fire(rise, d);
    finish_pulse();
  endtask

  task automatic check_idle_quiet(input string name);
    chk({name, "_state"}, state_o, 0);
    chk({name, "_trst"}, target_reset_o, 0);
    chk({name, "_pulse"}, pulse_start_o, 0);
    chk({name, "_done"}, done_o, 0);
  endtask

  initial begin
    rst = 1'b1; arm_i = 1'b0; abort_i = 1'b0; reset_target_i = 1'b0; trig_edge_i = 1'b0;
    delay_i = 16'd0; trigger_i = 1'b0; pulser_ready_i = 1'b1;
    step(3);
    rst = 1'b0;
    check_idle_quiet("reset");
    chk("reset_busy", busy_o, 0);

    run_seq(0, 1, 10);

    // Target reset with trigger wiggling during it, then falling edge with zero delay.
    settle_trigger(1'b1);
    do_arm(1, 0, 0, RC);
    step(1); trigger_i = 1'b0;
    step(2); trigger_i = 1'b1;
    step(RC + 2);
    chk("wait_trig_after_trst", state_o, 2);
    fire(0, 0);
    finish_pulse();

    // Trigger already high at arm in rising mode must not fire.
    settle_trigger(1'b1);
    do_arm(0, 1, 3, RC);
    step(10);
    chk("no_fire_on_level", state_o, 2);
    settle_trigger(1'b0);
    fire(1, 3);
    finish_pulse();

    // Abort mid-delay.
    settle_trigger(1'b0);
    do_arm(0, 1, 1000, RC);
    step(2);
    trigger_i = 1'b1;
    step(3 + 500);
    chk("in_delay", state_o, 3);
    abort_i = 1'b1; step(1); abort_i = 1'b0;
    check_idle_quiet("abort_delay");
    step(600);

    // Abort during target reset: pulse cut to 3 cycles.
    settle_trigger(1'b0);
    do_arm(1, 1, 5, 3);
    step(2);
    abort_i = 1'b1; step(1); abort_i = 1'b0;
    check_idle_quiet("abort_trst");
    step(5);

    // Arm and abort together.
    arm_i = 1'b1; abort_i = 1'b1; delay_i = 16'd4;
    step(1);
    arm_i = 1'b0; abort_i = 1'b0;
    chk("arm_abort_state", state_o, 0);
    chk("arm_abort_busy", busy_o, 0);

    // Arm while pulser busy is ignored.
    pulser_ready_i = 1'b0;
    arm_i = 1'b1; step(1); arm_i = 1'b0;
    chk("arm_not_ready", busy_o, 0);
    pulser_ready_i = 1'b1;

    // Re-arm during WAIT_TRIG ignored; original delay honoured.
    settle_trigger(1'b0);
    do_arm(0, 1, 5, RC);
    arm_i = 1'b1; delay_i = 16'd40; reset_target_i = 1'b1; step(1); arm_i = 1'b0;
    chk("rearm_ignored", state_o, 2);
    step(1);
    fire(1, 5);
    finish_pulse();

    // Reset in WAIT_DONE.
    settle_trigger(1'b0);
    do_arm(0, 1, 2, RC);
    step(2);
    fire(1, 2);
    pulser_ready_i = 1'b0;
    step(2);
    rst = 1'b1; step(1);
    check_idle_quiet("rst_wait_done");
    chk("rst_busy", busy_o, 0);
    rst = 1'b0;
    pulser_ready_i = 1'b1;
    step(3);

    for (int i = 0; i < 8; i++) begin
      run_seq(1'($urandom), 1'($urandom), int'($urandom_range(0, 40)));
    end

    run_seq(0, 1, 65535);

    step(5);
    chk("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
